// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state encoding and
// frame-length helpers used by the transmitter and by the UART benches.
package uart_pkg;

    // Parity mode encodings for P_UART_CHECK. Any other value means "no parity".
    localparam int CHECK_NONE = 0;
    localparam int CHECK_ODD  = 1;
    localparam int CHECK_EVEN = 2;

    // Transmitter frame states, in line order.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // True when the parity mode inserts a parity bit; illegal modes act as none.
    function automatic bit has_parity(input int check);
        return (check == CHECK_ODD) || (check == CHECK_EVEN);
    endfunction

    // Cycles per frame: start + data + optional parity + stop cycles.
    function automatic int frame_len(input int data_width, input int stop_width,
                                     input int check);
        return 1 + data_width + (has_parity(check) ? 1 : 0) + stop_width;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one line bit per i_clk cycle. Accepts a word over a
// valid/ready handshake and sends start, LSB-first data, optional parity and
// stop bits. Every output comes straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int P_UART_CLK        = 250_000_000,
    parameter int P_UART_BAUDRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_usr_tx_data,
    input  logic                         i_usr_tx_valid,
    output logic                         o_usr_tx_ready,
    output logic                         o_uart_tx
);

    // Bit counter only has to reach the larger of the data and stop cycle counts.
    localparam int C_CNT_W_RAW = $clog2(P_UART_DATA_WIDTH + 1);
    localparam int C_CNT_W     = (C_CNT_W_RAW < 1) ? 1 : C_CNT_W_RAW;

    localparam bit                 C_HAS_PARITY = has_parity(P_UART_CHECK);
    localparam bit                 C_ODD        = (P_UART_CHECK == CHECK_ODD);
    localparam logic [C_CNT_W-1:0] C_DATA_LAST  = C_CNT_W'(P_UART_DATA_WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_STOP_LAST  = C_CNT_W'(P_UART_STOP_WIDTH - 1);
    localparam bit                 C_ONE_STOP   = (P_UART_STOP_WIDTH == 1);

    // Clock and baud rate are carried for documentation; the line runs at i_clk.
    localparam int C_INFO_CLK  = P_UART_CLK;
    localparam int C_INFO_BAUD = P_UART_BAUDRATE;

    tx_state_t                    r_state;
    logic [C_CNT_W-1:0]           r_cnt;
    logic [P_UART_DATA_WIDTH-1:0] r_shift;
    logic                         r_parity;
    logic                         r_tx;
    logic                         r_ready;

    tx_state_t                    w_state_nxt;
    logic [C_CNT_W-1:0]           w_cnt_nxt;
    logic [P_UART_DATA_WIDTH-1:0] w_shift_nxt;
    logic                         w_parity_nxt;
    logic                         w_tx_nxt;
    logic                         w_ready_nxt;
    logic                         w_accept;
    logic                         w_parity_in;

    // Handshake uses the registered ready, so valid never reaches ready combinationally.
    assign w_accept = i_usr_tx_valid && r_ready;

    // Parity of the incoming word; latched at accept so later input changes do not matter.
    assign w_parity_in = C_ODD ? ~(^i_usr_tx_data) : (^i_usr_tx_data);

    // Next-state and next-output logic: outputs are computed one cycle ahead
    // so the flops present the value that belongs to the upcoming state.
    // NOTE: every signal gets a default before the case; a path that forgets to
    // assign one would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = 1'b1;
        w_ready_nxt  = 1'b0;

        if (w_accept) begin
            // Accept is possible in IDLE or the last stop cycle; both go to START.
            w_state_nxt  = TX_START;
            w_cnt_nxt    = '0;
            w_shift_nxt  = i_usr_tx_data;
            w_parity_nxt = w_parity_in;
            w_tx_nxt     = 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    w_ready_nxt = 1'b1;
                end

                TX_START: begin
                    w_state_nxt = TX_DATA;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end

                TX_DATA: begin
                    if (r_cnt == C_DATA_LAST) begin
                        w_cnt_nxt = '0;
                        if (C_HAS_PARITY) begin
                            w_state_nxt = TX_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            // A single stop cycle is also the last one, so ready opens now.
                            w_state_nxt = TX_STOP;
                            w_ready_nxt = C_ONE_STOP;
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end

                TX_PARITY: begin
                    w_state_nxt = TX_STOP;
                    w_cnt_nxt   = '0;
                    w_ready_nxt = C_ONE_STOP;
                end

                TX_STOP: begin
                    if (r_cnt == C_STOP_LAST) begin
                        w_state_nxt = TX_IDLE;
                        w_cnt_nxt   = '0;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_ready_nxt = ((r_cnt + 1'b1) == C_STOP_LAST);
                    end
                end

                default: begin
                    w_state_nxt = TX_IDLE;
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                end
            endcase
        end
    end

    // State, datapath and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the shift register is reset too; it is a plain register, not a RAM,
    // so the reset costs nothing and keeps post-reset state fully defined.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign o_uart_tx      = r_tx;
    assign o_usr_tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a table of single-frame vectors over five
// parameterisations, plus hand-written sequences for back-to-back frames,
// reset behaviour and a loopback decode of an 8E1 stream.
module tb_uart_tx;

    localparam int N_DUT = 5;

    logic       clk;
    logic       rst;
    logic [7:0] tb_data  [N_DUT];
    logic       tb_valid [N_DUT];
    logic       tb_ready [N_DUT];
    logic       tb_tx    [N_DUT];

    int n_checks;
    int n_errors;

    // Instance 0: 8N1, 1: 8O1, 2: 8E1, 3: 8N2, 4: illegal parity mode 3.
    uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(tb_data[0]), .i_usr_tx_valid(tb_valid[0]),
        .o_usr_tx_ready(tb_ready[0]), .o_uart_tx(tb_tx[0]));
    uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_8o1 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(tb_data[1]), .i_usr_tx_valid(tb_valid[1]),
        .o_usr_tx_ready(tb_ready[1]), .o_uart_tx(tb_tx[1]));
    uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(tb_data[2]), .i_usr_tx_valid(tb_valid[2]),
        .o_usr_tx_ready(tb_ready[2]), .o_uart_tx(tb_tx[2]));
    uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) u_8n2 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(tb_data[3]), .i_usr_tx_valid(tb_valid[3]),
        .o_usr_tx_ready(tb_ready[3]), .o_uart_tx(tb_tx[3]));
    uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(3)) u_8x1 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(tb_data[4]), .i_usr_tx_valid(tb_valid[4]),
        .o_usr_tx_ready(tb_ready[4]), .o_uart_tx(tb_tx[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges despite the per-wait budgets.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the caller at a negedge where the selected instance shows ready.
    task automatic wait_ready(input int idx, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (tb_ready[idx] === 1'b1) seen = 1'b1;
        end
        if (!seen) check(name, 32'd0, 32'd1);
    endtask

    // Single-frame vectors. line/rdy hold the per-cycle values in transmission
    // order, first cycle (the start bit) in bit len-1.
    typedef struct {
        int          idx;
        logic [7:0]  word;
        int          len;
        logic [15:0] line;
        logic [15:0] rdy;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int v);
        logic [15:0] act_line;
        logic [15:0] act_rdy;
        int          idx;
        idx      = vecs[v].idx;
        act_line = '0;
        act_rdy  = '0;
        wait_ready(idx, $sformatf("vec%0d ready before send", v));
        tb_data[idx]  = vecs[v].word;
        tb_valid[idx] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < vecs[v].len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Scramble the live input so parity must come from the captured word.
                tb_valid[idx] = 1'b0;
                tb_data[idx]  = ~vecs[v].word;
            end
            act_line = {act_line[14:0], tb_tx[idx]};
            act_rdy  = {act_rdy[14:0], tb_ready[idx]};
        end
        check($sformatf("vec%0d line", v), 32'(act_line), 32'(vecs[v].line));
        check($sformatf("vec%0d ready", v), 32'(act_rdy), 32'(vecs[v].rdy));
        @(negedge clk);
        check($sformatf("vec%0d idle after frame {tx,ready}", v),
              32'({tb_tx[idx], tb_ready[idx]}), 32'b11);
    endtask

    // Bench-side 8E1 receiver used for the loopback sequence.
    bit         rx_busy;
    int         rx_cnt;
    logic [7:0] rx_sh;
    int         rx_bad;
    logic [7:0] rx_words [$];

    task automatic rx_step(input logic b);
        if (!rx_busy) begin
            if (b == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_sh   = '0;
            end
        end else if (rx_cnt < 8) begin
            rx_sh  = {b, rx_sh[7:1]};
            rx_cnt = rx_cnt + 1;
        end else if (rx_cnt == 8) begin
            if (b !== (^rx_sh)) rx_bad = rx_bad + 1;
            rx_cnt = rx_cnt + 1;
        end else begin
            if (b !== 1'b1) rx_bad = rx_bad + 1;
            rx_words.push_back(rx_sh);
            rx_busy = 1'b0;
        end
    endtask

    initial begin
        logic [19:0] b2b_line;
        logic [7:0]  lb_words [4];
        int          accepts;
        logic        rdy_b;
        bit          saw_low;

        n_checks = 0;
        n_errors = 0;
        rx_busy  = 1'b0;
        rx_cnt   = 0;
        rx_sh    = '0;
        rx_bad   = 0;

        vecs[0] = '{idx: 0, word: 8'hA5, len: 10, line: 16'b0101001011,  rdy: 16'b0000000001};
        vecs[1] = '{idx: 1, word: 8'hA5, len: 11, line: 16'b01010010111, rdy: 16'b00000000001};
        vecs[2] = '{idx: 2, word: 8'hA5, len: 11, line: 16'b01010010101, rdy: 16'b00000000001};
        vecs[3] = '{idx: 2, word: 8'h01, len: 11, line: 16'b01000000011, rdy: 16'b00000000001};
        vecs[4] = '{idx: 3, word: 8'h3C, len: 11, line: 16'b00011110011, rdy: 16'b00000000001};
        vecs[5] = '{idx: 4, word: 8'hA5, len: 10, line: 16'b0101001011,  rdy: 16'b0000000001};
        vecs[6] = '{idx: 1, word: 8'h00, len: 11, line: 16'b00000000011, rdy: 16'b00000000001};

        lb_words[0] = 8'h00;
        lb_words[1] = 8'h55;
        lb_words[2] = 8'hAA;
        lb_words[3] = 8'hFF;

        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            tb_data[i]  = '0;
            tb_valid[i] = 1'b0;
        end

        // Reset state, then ready one edge after release.
        repeat (3) @(negedge clk);
        check("reset 8n1 {tx,ready}", 32'({tb_tx[0], tb_ready[0]}), 32'b10);
        check("reset 8n2 {tx,ready}", 32'({tb_tx[3], tb_ready[3]}), 32'b10);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset release", 32'(tb_ready[0]), 32'd1);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Back-to-back on 8N1: valid held, 0x00 then 0xFF, 20 cycles of line.
        wait_ready(0, "b2b ready before send");
        tb_data[0]  = 8'h00;
        tb_valid[0] = 1'b1;
        accepts     = 0;
        b2b_line    = '0;
        for (int c = 0; c < 20; c++) begin
            rdy_b = tb_ready[0];
            @(posedge clk);
            if (tb_valid[0] && rdy_b) accepts++;
            @(negedge clk);
            if (accepts == 1) tb_data[0] = 8'hFF;
            if (c == 19) tb_valid[0] = 1'b0;
            b2b_line = {b2b_line[18:0], tb_tx[0]};
        end
        check("b2b line", 32'(b2b_line), 32'(20'b0_00000000_1_0_11111111_1));
        check("b2b accept count", 32'(accepts), 32'd2);
        @(negedge clk);
        check("b2b idle after frames {tx,ready}", 32'({tb_tx[0], tb_ready[0]}), 32'b11);

        // Reset during data bit 3 of 0xA5 on 8N1.
        wait_ready(0, "midreset ready before send");
        tb_data[0]  = 8'hA5;
        tb_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset data bit 3", 32'(tb_tx[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset during reset {tx,ready}", 32'({tb_tx[0], tb_ready[0]}), 32'b10);
        rst = 1'b0;
        @(negedge clk);
        check("midreset after release {tx,ready}", 32'({tb_tx[0], tb_ready[0]}), 32'b11);
        saw_low = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tb_tx[0] !== 1'b1) saw_low = 1'b1;
        end
        check("midreset no resumed bits", 32'(saw_low), 32'd0);

        // Reset and valid together: nothing is accepted.
        rst         = 1'b1;
        tb_valid[0] = 1'b1;
        tb_data[0]  = 8'h00;
        @(negedge clk);
        rst         = 1'b0;
        tb_valid[0] = 1'b0;
        check("rst+valid {tx,ready}", 32'({tb_tx[0], tb_ready[0]}), 32'b10);
        saw_low = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tb_tx[0] !== 1'b1) saw_low = 1'b1;
        end
        check("rst+valid line stays idle", 32'(saw_low), 32'd0);

        // Loopback 8E1: four words back-to-back decoded by the bench receiver.
        wait_ready(2, "loopback ready before send");
        tb_data[2]  = lb_words[0];
        tb_valid[2] = 1'b1;
        accepts     = 0;
        for (int c = 0; c < 80 && rx_words.size() < 4; c++) begin
            rdy_b = tb_ready[2];
            @(posedge clk);
            if (tb_valid[2] && rdy_b) accepts++;
            @(negedge clk);
            if (accepts >= 4) tb_valid[2] = 1'b0;
            else tb_data[2] = lb_words[accepts];
            rx_step(tb_tx[2]);
        end
        tb_valid[2] = 1'b0;
        check("loopback accepts", 32'(accepts), 32'd4);
        check("loopback word count", 32'(rx_words.size()), 32'd4);
        check("loopback parity/stop errors", 32'(rx_bad), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_words.size())
                check($sformatf("loopback word %0d", i), 32'(rx_words[i]), 32'(lb_words[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
